// File: rtl/food_place_ctrl_if.sv
// ---------------------------------------------------------------------------
// food_place_ctrl_if
// Bundle of the signals that connect the food placement sequencer to the
// game-state FSM, the random source and the block-map read port.
//
//   PlaceReq   game FSM -> ctrl   level request for a new food position
//   RandV/H    random   -> ctrl   candidate row/column, new value each cycle
//   ReadV/H    ctrl     -> map    block-map read address (registered)
//   ReadData   map      -> ctrl   block-map entry, one cycle after address
//   Busy       ctrl     -> game   high while a search is in progress
//   FoodValid  ctrl     -> game   one-cycle pulse, FoodV/FoodH updated
//   FoodFail   ctrl     -> game   one-cycle pulse, no empty interior cell
//   FoodV/H    ctrl     -> game   last placed food position
//
// The slave modport is the controller's view; master is the environment's.
// ---------------------------------------------------------------------------
interface food_place_ctrl_if #(
    parameter int GRID_HEIGHT    = 30,
    parameter int GRID_WIDTH     = 40,
    parameter int BITS_PER_BLOCK = 2
);
    localparam int VW = $clog2(GRID_HEIGHT);
    localparam int HW = $clog2(GRID_WIDTH);

    logic                      PlaceReq;
    logic [VW-1:0]             RandV;
    logic [HW-1:0]             RandH;
    logic [VW-1:0]             ReadV;
    logic [HW-1:0]             ReadH;
    logic [BITS_PER_BLOCK-1:0] ReadData;
    logic                      Busy;
    logic                      FoodValid;
    logic                      FoodFail;
    logic [VW-1:0]             FoodV;
    logic [HW-1:0]             FoodH;

    modport slave (
        input  PlaceReq, RandV, RandH, ReadData,
        output ReadV, ReadH, Busy, FoodValid, FoodFail, FoodV, FoodH
    );

    modport master (
        output PlaceReq, RandV, RandH, ReadData,
        input  ReadV, ReadH, Busy, FoodValid, FoodFail, FoodV, FoodH
    );
endinterface

// File: rtl/food_place_ctrl.sv
// ---------------------------------------------------------------------------
// food_place_ctrl
// Finds an empty interior grid cell for the next food item. Random candidates
// are tried first; after MAX_TRIES misses a row-major scan of the interior
// takes over, which either finds an empty cell or reports that none exists.
//
// Ports:
//   MasterClock  single clock, rising edge
//   Reset        synchronous, active-high
//   bus          food_place_ctrl_if.slave (request/result handshake,
//                random candidates, block-map read port)
// All outputs are registered.
// ---------------------------------------------------------------------------
module food_place_ctrl #(
    parameter int GRID_HEIGHT    = 30,
    parameter int GRID_WIDTH     = 40,
    parameter int BITS_PER_BLOCK = 2,
    parameter int BLOCK_EMPTY    = 0,
    parameter int MAX_TRIES      = 16
) (
    input  logic              MasterClock,
    input  logic              Reset,
    food_place_ctrl_if.slave  bus
);
    localparam int VW = $clog2(GRID_HEIGHT);
    localparam int HW = $clog2(GRID_WIDTH);
    localparam int TW = $clog2(MAX_TRIES + 1);

    localparam logic [VW-1:0] V_FIRST = VW'(1);
    localparam logic [HW-1:0] H_FIRST = HW'(1);
    localparam logic [VW-1:0] V_LAST  = VW'(GRID_HEIGHT - 2);
    localparam logic [HW-1:0] H_LAST  = HW'(GRID_WIDTH - 2);
    localparam logic [TW-1:0] TRY_LAST = TW'(MAX_TRIES - 1);
    localparam logic [BITS_PER_BLOCK-1:0] EMPTY_CODE = BITS_PER_BLOCK'(BLOCK_EMPTY);

    typedef enum logic [2:0] {
        IDLE, R_ISSUE, R_WAIT, R_CHECK, S_ISSUE, S_WAIT, S_CHECK
    } state_t;

    state_t        state_q;
    logic [TW-1:0] try_q;
    logic [VW-1:0] scan_v_q;
    logic [HW-1:0] scan_h_q;
    logic [VW-1:0] read_v_q;
    logic [HW-1:0] read_h_q;
    logic [VW-1:0] food_v_q;
    logic [HW-1:0] food_h_q;
    logic          busy_q;
    logic          valid_q;
    logic          fail_q;

    logic          rand_interior;
    logic          cell_empty;
    logic          last_try;
    logic          scan_at_end;
    logic [TW-1:0] try_d;

    always_comb begin
        rand_interior = (bus.RandV >= V_FIRST) && (bus.RandV <= V_LAST) &&
                        (bus.RandH >= H_FIRST) && (bus.RandH <= H_LAST);
        cell_empty    = (bus.ReadData == EMPTY_CODE);
        // The try being retired now is the MAX_TRIES-th one.
        last_try      = (try_q == TRY_LAST);
        scan_at_end   = (scan_v_q == V_LAST) && (scan_h_q == H_LAST);
        try_d         = try_q + TW'(1);
    end

    always_ff @(posedge MasterClock) begin
        if (Reset) begin
            state_q  <= IDLE;
            try_q    <= '0;
            scan_v_q <= '0;
            scan_h_q <= '0;
            read_v_q <= '0;
            read_h_q <= '0;
            food_v_q <= '0;
            food_h_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            fail_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.PlaceReq) begin
                        state_q <= R_ISSUE;
                        try_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                R_ISSUE: begin
                    // Out-of-interior candidates are dropped without a read.
                    if (rand_interior) begin
                        read_v_q <= bus.RandV;
                        read_h_q <= bus.RandH;
                        state_q  <= R_WAIT;
                    end else begin
                        try_q <= try_d;
                        if (last_try) begin
                            scan_v_q <= V_FIRST;
                            scan_h_q <= H_FIRST;
                            state_q  <= S_ISSUE;
                        end
                    end
                end
                R_WAIT: state_q <= R_CHECK;
                R_CHECK: begin
                    // The read address still holds the candidate under test.
                    if (cell_empty) begin
                        food_v_q <= read_v_q;
                        food_h_q <= read_h_q;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        try_q <= try_d;
                        if (last_try) begin
                            scan_v_q <= V_FIRST;
                            scan_h_q <= H_FIRST;
                            state_q  <= S_ISSUE;
                        end else begin
                            state_q <= R_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    read_v_q <= scan_v_q;
                    read_h_q <= scan_h_q;
                    state_q  <= S_WAIT;
                end
                S_WAIT: state_q <= S_CHECK;
                S_CHECK: begin
                    if (cell_empty) begin
                        food_v_q <= scan_v_q;
                        food_h_q <= scan_h_q;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else if (scan_at_end) begin
                        fail_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        if (scan_h_q == H_LAST) begin
                            scan_h_q <= H_FIRST;
                            scan_v_q <= scan_v_q + VW'(1);
                        end else begin
                            scan_h_q <= scan_h_q + HW'(1);
                        end
                        state_q <= S_ISSUE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ReadV     = read_v_q;
    assign bus.ReadH     = read_h_q;
    assign bus.Busy      = busy_q;
    assign bus.FoodValid = valid_q;
    assign bus.FoodFail  = fail_q;
    assign bus.FoodV     = food_v_q;
    assign bus.FoodH     = food_h_q;
endmodule
